// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM pipeline stage plus the MEM/WB pipeline register.
// Handshakes with a data memory through a req/ack pair and holds upstream
// stages with 'stall' while an access is outstanding. Branch resolution is
// forwarded to the PC mux combinationally.
// Optional feature: define MEM_TIMEOUT_EN to add a 4-bit access timeout
// counter and the mem_err pulse output.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_In,
  input  logic        MemtoReg_In,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic        Branch_In,
  input  logic        Zero_In,
  input  logic [31:0] b_tgt_In,
  input  logic [31:0] alu_out_In,
  input  logic [31:0] RD2_In,
  input  logic [4:0]  rfile_wn_In,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] pc_tgt,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic [31:0] mem_rdata,
  output logic [31:0] alu_out,
  output logic [4:0]  rfile_wn
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        mem_err
`endif
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state;
  state_t state_nxt;
  logic   access;
  logic   bubble;
`ifdef MEM_TIMEOUT_EN
  logic [3:0] cnt;
  logic       timeout;
`endif

  // Branch resolution and memory address/data are pure pass-through.
  assign PCSrc      = Branch_In & Zero_In;
  assign pc_tgt     = b_tgt_In;
  assign dmem_addr  = alu_out_In;
  assign dmem_wdata = RD2_In;
  assign access     = MemRead_In | MemWrite_In;
  // A read wins when both controls are set.
  assign dmem_we    = MemWrite_In & ~MemRead_In;

  // Request/stall decode and next-state selection.
  always_comb begin
    dmem_req  = 1'b0;
    stall     = 1'b0;
    state_nxt = state;
`ifdef MEM_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      IDLE: begin
        // An ack seen here belongs to an abandoned access and is ignored.
        if (access) begin
          dmem_req  = 1'b1;
          stall     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_nxt = IDLE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (cnt == 4'd15) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stall = 1'b1;
          end
`else
          stall = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A timed-out access releases upstream but must not write back.
`ifdef MEM_TIMEOUT_EN
  assign bubble = stall | timeout;
`else
  assign bubble = stall;
`endif

  // FSM state, timeout counter and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef MEM_TIMEOUT_EN
      cnt     <= 4'd0;
      mem_err <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
`ifdef MEM_TIMEOUT_EN
      mem_err <= timeout;
      if (state == IDLE)
        cnt <= 4'd0;
      else if (!dmem_ack && cnt != 4'd15)
        cnt <= cnt + 4'd1;
`endif
    end
  end

  // MEM/WB register: full load when free, control bubble otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      MemtoReg  <= 1'b0;
      mem_rdata <= 32'd0;
      alu_out   <= 32'd0;
      rfile_wn  <= 5'd0;
    end else if (bubble) begin
      RegWrite <= 1'b0;
      MemtoReg <= 1'b0;
    end else begin
      RegWrite  <= RegWrite_In;
      MemtoReg  <= MemtoReg_In;
      mem_rdata <= dmem_rdata;
      alu_out   <= alu_out_In;
      rfile_wn  <= rfile_wn_In;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU pass-through, branch, load,
// store, read/write priority, back-to-back re-issue, reset mid-access and
// (with MEM_TIMEOUT_EN) the timeout path.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_In, MemtoReg_In, MemRead_In, MemWrite_In;
  logic        Branch_In, Zero_In;
  logic [31:0] b_tgt_In, alu_out_In, RD2_In, dmem_rdata;
  logic [4:0]  rfile_wn_In;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall, PCSrc;
  logic [31:0] dmem_addr, dmem_wdata, pc_tgt, mem_rdata, alu_out;
  logic        RegWrite, MemtoReg;
  logic [4:0]  rfile_wn;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .RegWrite_In(RegWrite_In), .MemtoReg_In(MemtoReg_In),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
    .Branch_In(Branch_In), .Zero_In(Zero_In),
    .b_tgt_In(b_tgt_In), .alu_out_In(alu_out_In), .RD2_In(RD2_In),
    .rfile_wn_In(rfile_wn_In), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .stall(stall), .PCSrc(PCSrc), .pc_tgt(pc_tgt),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .mem_rdata(mem_rdata),
    .alu_out(alu_out), .rfile_wn(rfile_wn)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    RegWrite_In = 0; MemtoReg_In = 0; MemRead_In = 0; MemWrite_In = 0;
    Branch_In = 0; Zero_In = 0; b_tgt_In = 0; alu_out_In = 0; RD2_In = 0;
    rfile_wn_In = 0; dmem_rdata = 0; dmem_ack = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_regwrite", {31'd0, RegWrite}, 0);
    chk("rst_memtoreg", {31'd0, MemtoReg}, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_rfile_wn", {27'd0, rfile_wn}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_req", {31'd0, dmem_req}, 0);
`ifdef MEM_TIMEOUT_EN
    chk("rst_mem_err", {31'd0, mem_err}, 0);
`endif

    // ALU op: no memory access, straight through in one cycle.
    tick();
    RegWrite_In = 1; alu_out_In = 32'h7; rfile_wn_In = 5'd3;
    #1;
    chk("alu_req", {31'd0, dmem_req}, 0);
    chk("alu_stall", {31'd0, stall}, 0);
    tick();
    chk("alu_out", alu_out, 32'h7);
    chk("alu_regwrite", {31'd0, RegWrite}, 1);
    chk("alu_wn", {27'd0, rfile_wn}, 3);

    // Branch resolution, same cycle.
    Branch_In = 1; Zero_In = 1; b_tgt_In = 32'h100;
    #1;
    chk("br_pcsrc", {31'd0, PCSrc}, 1);
    chk("br_tgt", pc_tgt, 32'h100);
    Zero_In = 0;
    #1;
    chk("br_nz_pcsrc", {31'd0, PCSrc}, 0);
    Branch_In = 0;

    // Load, ack on the 3rd cycle.
    MemRead_In = 1; MemtoReg_In = 1; RegWrite_In = 1;
    alu_out_In = 32'h40; rfile_wn_In = 5'd8;
    #1;
    chk("ld_c1_req", {31'd0, dmem_req}, 1);
    chk("ld_c1_stall", {31'd0, stall}, 1);
    chk("ld_we", {31'd0, dmem_we}, 0);
    chk("ld_addr", dmem_addr, 32'h40);
    tick();
    chk("ld_c2_stall", {31'd0, stall}, 1);
    chk("ld_c2_req", {31'd0, dmem_req}, 1);
    chk("ld_bubble_rw", {31'd0, RegWrite}, 0);
    chk("ld_bubble_hold", alu_out, 32'h7);
    tick();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_c3_stall", {31'd0, stall}, 0);
    chk("ld_c3_req", {31'd0, dmem_req}, 1);
    tick();
    dmem_ack = 0; MemRead_In = 0; MemtoReg_In = 0;
    chk("ld_regwrite", {31'd0, RegWrite}, 1);
    chk("ld_memtoreg", {31'd0, MemtoReg}, 1);
    chk("ld_rdata", mem_rdata, 32'hDEADBEEF);
    chk("ld_wn", {27'd0, rfile_wn}, 8);
    chk("ld_alu", alu_out, 32'h40);

    // Store, ack on the 2nd cycle.
    MemWrite_In = 1; RegWrite_In = 0; RD2_In = 32'h12345678; alu_out_In = 32'h80;
    #1;
    chk("st_we", {31'd0, dmem_we}, 1);
    chk("st_wdata", dmem_wdata, 32'h12345678);
    chk("st_c1_stall", {31'd0, stall}, 1);
    tick();
    dmem_ack = 1;
    #1;
    chk("st_c2_stall", {31'd0, stall}, 0);
    tick();
    dmem_ack = 0; MemWrite_In = 0;
    chk("st_regwrite", {31'd0, RegWrite}, 0);
    chk("st_alu", alu_out, 32'h80);

    // Read and write both set: read wins. Held across ack to see re-issue.
    MemRead_In = 1; MemWrite_In = 1;
    #1;
    chk("rw_we", {31'd0, dmem_we}, 0);
    tick();
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    #1;
    chk("b2b_req", {31'd0, dmem_req}, 1);
    chk("b2b_stall", {31'd0, stall}, 1);
    MemWrite_In = 0;

    // Reset while in ACCESS, then a late ack in IDLE.
    tick();
    chk("rs_in_access", {31'd0, stall}, 1);
    rst = 1;
    tick();
    rst = 0; MemRead_In = 0; RegWrite_In = 0;
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("rs_regwrite", {31'd0, RegWrite}, 0);
    chk("rs_rdata", mem_rdata, 0);
    chk("rs_alu", alu_out, 0);
    chk("rs_wn", {27'd0, rfile_wn}, 0);
    chk("rs_late_req", {31'd0, dmem_req}, 0);
    chk("rs_late_stall", {31'd0, stall}, 0);
    tick();
    dmem_ack = 0;
    chk("rs_after_req", {31'd0, dmem_req}, 0);

`ifdef MEM_TIMEOUT_EN
    // Timeout: no ack ever arrives.
    MemRead_In = 1; RegWrite_In = 1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("to_stall", {31'd0, stall}, 1);
      chk("to_err_low", {31'd0, mem_err}, 0);
      tick();
    end
    chk("to_release", {31'd0, stall}, 0);
    tick();
    MemRead_In = 0; RegWrite_In = 0;
    chk("to_err", {31'd0, mem_err}, 1);
    chk("to_bubble", {31'd0, RegWrite}, 0);
    tick();
    chk("to_err_pulse", {31'd0, mem_err}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
